// File: rtl/ifm_chunk_pingpong_ctrl.sv
// Ping-pong controller for two input-feature-map chunk banks: fills one bank
// from the upstream beat stream while the compute array reads the other.
module ifm_chunk_pingpong_ctrl #(
    parameter int unsigned MEM_SIZE         = 128,
    parameter int unsigned BUS_SIZE         = 32,
    parameter int unsigned COMPUTE_UNIT_NUM = 4,
    localparam int unsigned WR_CYC_NUM      = MEM_SIZE / BUS_SIZE,
    localparam int unsigned CNT_W           = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic                        wr_valid_o,
    output logic                        wr_sel_o,
    output logic [CNT_W-1:0]            wr_count_o,
    input  logic                        chunk_req_i,
    output logic                        chunk_start_o,
    output logic                        rd_sel_o,
    input  logic [COMPUTE_UNIT_NUM-1:0] cu_done_i,
    output logic [1:0]                  bank_full_o,
    output logic                        err_o
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    bank_state_e                 bank_q [2];
    bank_state_e                 bank_d [2];
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [COMPUTE_UNIT_NUM-1:0] mask_q, mask_d;
    logic                        chunk_start_q, chunk_start_d;
    logic                        rd_sel_q, rd_sel_d;
    logic                        err_q, err_d;

    logic in_ready;
    logic accept;
    logic last_beat;
    logic reading_any;
    logic grant;
    logic done_all;

    assign in_ready    = (bank_q[wr_ptr_q] == BANK_EMPTY) || (bank_q[wr_ptr_q] == BANK_FILLING);
    assign accept      = in_valid_i & in_ready;
    assign last_beat   = (cnt_q == CNT_W'(WR_CYC_NUM - 1));
    assign reading_any = (bank_q[0] == BANK_READING) || (bank_q[1] == BANK_READING);
    // Requiring no READING bank also keeps a release and a grant off the same edge.
    assign grant       = chunk_req_i && (bank_q[rd_ptr_q] == BANK_FULL) && !reading_any;
    assign done_all    = &(mask_q | cu_done_i);

    always_comb begin
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        chunk_start_d = 1'b0;
        rd_sel_d      = rd_sel_q;
        err_d         = err_q;

        if (flush_i) begin
            bank_d[0] = BANK_EMPTY;
            bank_d[1] = BANK_EMPTY;
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            cnt_d     = '0;
            mask_d    = '0;
            rd_sel_d  = 1'b0;
            err_d     = 1'b0;
        end else begin
            // Write side only ever touches bank[wr_ptr], which cannot be FULL or READING here.
            if (accept) begin
                if (last_beat) begin
                    cnt_d            = '0;
                    bank_d[wr_ptr_q] = BANK_FULL;
                    wr_ptr_d         = ~wr_ptr_q;
                end else begin
                    cnt_d            = cnt_q + CNT_W'(1);
                    bank_d[wr_ptr_q] = BANK_FILLING;
                end
            end

            if (grant) begin
                bank_d[rd_ptr_q] = BANK_READING;
                rd_sel_d         = rd_ptr_q;
                chunk_start_d    = 1'b1;
            end

            // The READING bank is always bank[rd_ptr]: rd_ptr only moves on release.
            if (reading_any) begin
                if (done_all) begin
                    bank_d[rd_ptr_q] = BANK_EMPTY;
                    mask_d           = '0;
                    rd_ptr_d         = ~rd_ptr_q;
                end else begin
                    mask_d = mask_q | cu_done_i;
                end
            end else if (|cu_done_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q[0]     <= BANK_EMPTY;
            bank_q[1]     <= BANK_EMPTY;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            mask_q        <= '0;
            chunk_start_q <= 1'b0;
            rd_sel_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            chunk_start_q <= chunk_start_d;
            rd_sel_q      <= rd_sel_d;
            err_q         <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_status
            assign bank_full_o[gi] = (bank_q[gi] == BANK_FULL) || (bank_q[gi] == BANK_READING);
        end
    endgenerate

    assign in_ready_o    = in_ready;
    assign wr_valid_o    = accept;
    assign wr_sel_o      = wr_ptr_q;
    assign wr_count_o    = cnt_q;
    assign chunk_start_o = chunk_start_q;
    assign rd_sel_o      = rd_sel_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ifm_chunk_pingpong_ctrl.sv
// Directed bench for ifm_chunk_pingpong_ctrl: a vector table for the main
// fill/grant/release flow plus hand sequences for the multi-cycle corners.
module tb_ifm_chunk_pingpong_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       wr_valid_o;
    logic       wr_sel_o;
    logic [1:0] wr_count_o;
    logic       chunk_req_i;
    logic       chunk_start_o;
    logic       rd_sel_o;
    logic [3:0] cu_done_i;
    logic [1:0] bank_full_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ifm_chunk_pingpong_ctrl #(
        .MEM_SIZE        (128),
        .BUS_SIZE        (32),
        .COMPUTE_UNIT_NUM(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .wr_valid_o   (wr_valid_o),
        .wr_sel_o     (wr_sel_o),
        .wr_count_o   (wr_count_o),
        .chunk_req_i  (chunk_req_i),
        .chunk_start_o(chunk_start_o),
        .rd_sel_o     (rd_sel_o),
        .cu_done_i    (cu_done_i),
        .bank_full_o  (bank_full_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic       iv;
        logic       cr;
        logic       fl;
        logic [3:0] cu;
        logic       rdy;
        logic       wv;
        logic       ws;
        logic [1:0] wc;
        logic       cs;
        logic       rs;
        logic [1:0] bf;
        logic       err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic wv, input logic ws,
                            input logic [1:0] wc, input logic cs, input logic rs,
                            input logic [1:0] bf, input logic err);
        chk({tag, ".in_ready"},    32'(in_ready_o),    32'(rdy));
        chk({tag, ".wr_valid"},    32'(wr_valid_o),    32'(wv));
        chk({tag, ".wr_sel"},      32'(wr_sel_o),      32'(ws));
        chk({tag, ".wr_count"},    32'(wr_count_o),    32'(wc));
        chk({tag, ".chunk_start"}, 32'(chunk_start_o), 32'(cs));
        chk({tag, ".rd_sel"},      32'(rd_sel_o),      32'(rs));
        chk({tag, ".bank_full"},   32'(bank_full_o),   32'(bf));
        chk({tag, ".err"},         32'(err_o),         32'(err));
    endtask

    task automatic drive(input logic iv, input logic cr, input logic fl, input logic [3:0] cu);
        in_valid_i  = iv;
        chunk_req_i = cr;
        flush_i     = fl;
        cu_done_i   = cu;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        chunk_req_i = 1'b0;
        cu_done_i   = 4'b0;

        //          iv    cr    fl    cu       rdy   wv    ws    wc     cs    rs    bf     err
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0}); // 0 fill bank0
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0}); // 4 bank0 full, grant
        vq.push_back({1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0}); // 5 start pulse
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0}); // 6 one cycle only
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0}); // 7 repeat bit
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0}); // 8 fill bank1
        vq.push_back({1'b1, 1'b0, 1'b0, 4'hC, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b0}); // 9 release bank0
        vq.push_back({1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 1'b0}); // 12 grant bank1
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'b10, 1'b0}); // 14 refill bank0
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 2'b10, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 2'b10, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 2'b10, 1'b0});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'b11, 1'b0}); // 18 both busy
        vq.push_back({1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'b11, 1'b0}); // 19 release bank1
        vq.push_back({1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'b01, 1'b0}); // 20 grant bank0
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0});
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0});
        vq.push_back({1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0}); // 23 flush mid-read
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0});
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0}); // 25 stray done
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1});
        vq.push_back({1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1});
        vq.push_back({1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00, 1'b1}); // 28 flush wins
        vq.push_back({1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0});

        // Reset is asynchronous: outputs settle before the first clock edge.
        #1;
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        rst_ni = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].cr, vq[i].fl, vq[i].cu);
            $display("vec %0d iv=%0b cr=%0b fl=%0b cu=%h rdy=%0b wv=%0b ws=%0b wc=%0d cs=%0b rs=%0b bf=%b err=%0b",
                     i, vq[i].iv, vq[i].cr, vq[i].fl, vq[i].cu, in_ready_o, wr_valid_o, wr_sel_o,
                     wr_count_o, chunk_start_o, rd_sel_o, bank_full_o, err_o);
            chk_outs($sformatf("v%0d", i), vq[i].rdy, vq[i].wv, vq[i].ws, vq[i].wc,
                     vq[i].cs, vq[i].rs, vq[i].bf, vq[i].err);
            step();
        end

        // Release of bank0 and fill-complete of bank1 on the same edge.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0);
            chk($sformatf("sim.fill0.wc%0d", k), 32'(wr_count_o), 32'(k));
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        chk("sim.pre_grant.bf", 32'(bank_full_o), 32'(2'b01));
        step();
        drive(1'b1, 1'b0, 1'b0, 4'h7);
        chk_outs("sim.beat0", 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'h8);
        chk_outs("sim.beat3", 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'b01, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        $display("sim after coincident edge rdy=%0b ws=%0b bf=%b", in_ready_o, wr_sel_o, bank_full_o);
        chk_outs("sim.after", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk_outs("sim.grant1", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10, 1'b0);
        step();

        // Asynchronous reset mid-fill while bank1 is being read.
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("arst.beat0.wc", 32'(wr_count_o), 32'(0));
        step();
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("arst.beat1.wc", 32'(wr_count_o), 32'(1));
        step();
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        #2 rst_ni = 1'b0;
        #1;
        $display("arst asserted off-edge rdy=%0b wc=%0d bf=%b", in_ready_o, wr_count_o, bank_full_o);
        chk_outs("arst.now", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h0);
            chk_outs($sformatf("arst.refill%0d", k), 1'b1, 1'b1, 1'b0, 2'(k), 1'b0, 1'b0, 2'b00, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        chk_outs("arst.full", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk_outs("arst.start", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
